// File: rtl/truth_table_sweeper_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : truth_table_sweeper_if
// Brief   : Stimulus/response and result bundle between the sweeper and its
//           surroundings (block under test plus the controller reading results).
// Revision: 1.0 - initial release
// ============================================================================
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
) ();
  logic                  start;
  logic [N_IN-1:0]       stim;
  logic                  resp;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [N_IN:0]         err_count;
  logic [N_IN-1:0]       first_fail;
  logic [2**N_IN-1:0]    capture;

  // master = the sweeper itself, slave = block under test plus controller
  modport master (
    input  start, resp,
    output stim, busy, done, pass, err_count, first_fail, capture
  );

  modport slave (
    output start, resp,
    input  stim, busy, done, pass, err_count, first_fail, capture
  );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : truth_table_sweeper
// Brief   : Walks every input vector of an N_IN-input combinational block,
//           samples its output after a settle window and compares it against
//           a golden truth table. Optional macro STOP_ON_FAIL_EN ends the
//           sweep on the first mismatching vector.
// Revision: 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 1,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'b1110_1000
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.master bus
);

  localparam logic [1:0]      c_idle   = 2'd0;
  localparam logic [1:0]      c_run    = 2'd1;
  localparam logic [1:0]      c_done   = 2'd2;
  localparam logic [3:0]      c_settle = 4'(SETTLE);
  localparam logic [N_IN-1:0] c_last   = {N_IN{1'b1}};

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [N_IN-1:0]    r_stim;
  logic [N_IN-1:0]    r_first;
  logic [3:0]         r_hold;
  logic [N_IN:0]      r_err;
  logic [2**N_IN-1:0] r_capture;
  logic               r_pass;

  logic               w_start;
  logic               w_sample;
  logic               w_mismatch;
  logic               w_end;
  logic [N_IN:0]      w_err_next;

  assign w_start    = (r_state == c_idle) && bus.start;
  assign w_sample   = (r_state == c_run) && (r_hold == 4'd0);
  assign w_mismatch = (bus.resp != EXPECTED[r_stim]);
  assign w_err_next = r_err + (N_IN+1)'(w_mismatch);

`ifdef STOP_ON_FAIL_EN
  assign w_end = w_sample && ((r_stim == c_last) || w_mismatch);
`else
  assign w_end = w_sample && (r_stim == c_last);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (bus.start) w_next = c_run;
      c_run:   if (w_end)     w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == c_run);
    bus.done = (r_state == c_done);
  end

  // Sample on the last cycle of each vector's hold window, then advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stim    <= '0;
      r_hold    <= '0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_first   <= '0;
      r_capture <= '0;
    end else if (w_start) begin
      r_stim    <= '0;
      r_hold    <= c_settle;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_first   <= '0;
      r_capture <= '0;
    end else if (r_state == c_run) begin
      if (r_hold != 4'd0) begin
        r_hold <= r_hold - 4'd1;
      end else begin
        r_capture[r_stim] <= bus.resp;
        r_hold            <= c_settle;
        if (w_mismatch) begin
          r_err <= w_err_next;
          if (r_err == '0) r_first <= r_stim;
        end
        if (w_end) begin
          r_stim <= '0;
          r_pass <= (w_err_next == '0);
        end else begin
          r_stim <= r_stim + N_IN'(1);
        end
      end
    end
  end

  assign bus.stim       = r_stim;
  assign bus.pass       = r_pass;
  assign bus.err_count  = r_err;
  assign bus.first_fail = r_first;
  assign bus.capture    = r_capture;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_truth_table_sweeper
// Brief   : Scoreboard bench for truth_table_sweeper: default 3-input majority
//           instance plus a 4-input AND instance with no settle window.
// Revision: 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

  typedef struct {
    logic        pass;
    int          err;
    int          first;
    logic [15:0] cap;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rtab_a = 8'h00;
  logic [15:0] rtab_b = 16'h0000;
  int          checks = 0;
  int          passes = 0;
  int          cnt_a = 0;
  int          cnt_b = 0;
  exp_t        qa[$];
  exp_t        qb[$];

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) if_a ();
  truth_table_sweeper_if #(.N_IN(4)) if_b ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE8)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.master)
  );
  truth_table_sweeper #(.N_IN(4), .SETTLE(0), .EXPECTED(16'h8000)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.master)
  );

  // Block under test is modelled as a lookup of the bench's response table.
  assign if_a.resp = rtab_a[if_a.stim];
  assign if_b.resp = rtab_b[if_b.stim];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  // Reference: walk the vectors in order, score against the golden table.
  function automatic exp_t model(input logic [15:0] tab, input int n,
                                 input int settle, input logic [15:0] gold);
    exp_t r;
    int   used = 0;
    r.err = 0; r.first = 0; r.cap = '0;
    for (int i = 0; i < (1 << n); i++) begin
      r.cap[i] = tab[i];
      used++;
      if (tab[i] != gold[i]) begin
        if (r.err == 0) r.first = i;
        r.err++;
`ifdef STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    r.pass   = (r.err == 0);
    r.cycles = used * (settle + 1);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) cnt_a = 0;
    else begin
      if (if_a.busy) begin
        chk("stim_a", 32'(if_a.stim), 32'(cnt_a / 2));
        cnt_a++;
      end
      if (if_a.done) begin
        if (qa.size() == 0) begin
          checks++;
          $display("FAIL done_a unexpected pulse got=1 expected=0");
        end else begin
          e = qa.pop_front();
          chk("pass_a",  32'(if_a.pass),       32'(e.pass));
          chk("err_a",   32'(if_a.err_count),  32'(e.err));
          chk("cap_a",   32'(if_a.capture),    32'(e.cap[7:0]));
          chk("busy_a",  32'(cnt_a),           32'(e.cycles));
          if (e.err != 0) chk("first_a", 32'(if_a.first_fail), 32'(e.first));
        end
        cnt_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) cnt_b = 0;
    else begin
      if (if_b.busy) begin
        chk("stim_b", 32'(if_b.stim), 32'(cnt_b));
        cnt_b++;
      end
      if (if_b.done) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL done_b unexpected pulse got=1 expected=0");
        end else begin
          e = qb.pop_front();
          chk("pass_b", 32'(if_b.pass),      32'(e.pass));
          chk("err_b",  32'(if_b.err_count), 32'(e.err));
          chk("cap_b",  32'(if_b.capture),   32'(e.cap));
          chk("busy_b", 32'(cnt_b),          32'(e.cycles));
          if (e.err != 0) chk("first_b", 32'(if_b.first_fail), 32'(e.first));
        end
        cnt_b = 0;
      end
    end
  end

  task automatic wait_idle_a();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!if_a.busy && !if_a.done) return;
    end
    checks++;
    $display("FAIL idle_a timeout got=busy expected=idle");
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_a.done) return;
    end
    checks++;
    $display("FAIL done_a timeout got=none expected=pulse");
    if (qa.size() != 0) void'(qa.pop_back());
  endtask

  task automatic wait_done_b();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_b.done) return;
    end
    checks++;
    $display("FAIL done_b timeout got=none expected=pulse");
    if (qb.size() != 0) void'(qb.pop_back());
  endtask

  task automatic sweep_a(input logic [7:0] tab);
    wait_idle_a();
    rtab_a = tab;
    qa.push_back(model(16'(tab), 3, 1, 16'h00E8));
    if_a.start = 1'b1;
    @(posedge clk); #1 if_a.start = 1'b0;
    wait_done_a();
  endtask

  task automatic sweep_b(input logic [15:0] tab);
    @(negedge clk);
    rtab_b = tab;
    qb.push_back(model(tab, 4, 0, 16'h8000));
    if_b.start = 1'b1;
    @(posedge clk); #1 if_b.start = 1'b0;
    wait_done_b();
  endtask

  initial begin
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stim",  32'(if_a.stim),      32'd0);
    chk("rst_busy",  32'(if_a.busy),      32'd0);
    chk("rst_done",  32'(if_a.done),      32'd0);
    chk("rst_pass",  32'(if_a.pass),      32'd0);
    chk("rst_err",   32'(if_a.err_count), 32'd0);
    chk("rst_cap",   32'(if_a.capture),   32'd0);
    chk("rst_cap_b", 32'(if_b.capture),   32'd0);
    rst = 1'b0;

    sweep_a(8'hE8);
    sweep_a(8'h00);
    sweep_a(8'h17);
    for (int k = 0; k < 6; k++) sweep_a(8'($urandom));

    // Abort mid-sweep: everything must clear without waiting for a clock.
    wait_idle_a();
    rtab_a = 8'hE8;
    qa.push_back(model(16'h00E8, 3, 1, 16'h00E8));
    if_a.start = 1'b1;
    @(posedge clk); #1 if_a.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(qa.pop_back());
    chk("abort_busy",  32'(if_a.busy),       32'd0);
    chk("abort_done",  32'(if_a.done),       32'd0);
    chk("abort_stim",  32'(if_a.stim),       32'd0);
    chk("abort_err",   32'(if_a.err_count),  32'd0);
    chk("abort_first", 32'(if_a.first_fail), 32'd0);
    chk("abort_cap",   32'(if_a.capture),    32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    sweep_a(8'hE8);

    // start held through a whole sweep yields a single sweep
    wait_idle_a();
    rtab_a = 8'hE8;
    qa.push_back(model(16'h00E8, 3, 1, 16'h00E8));
    if_a.start = 1'b1;
    wait_done_a();
    if_a.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_busy", 32'(if_a.busy), 32'd0);

    // back-to-back: start during DONE takes effect from the following IDLE
    wait_idle_a();
    rtab_a = 8'h17;
    qa.push_back(model(16'h0017, 3, 1, 16'h00E8));
    if_a.start = 1'b1;
    @(posedge clk); #1 if_a.start = 1'b0;
    wait_done_a();
    rtab_a = 8'hE8;
    qa.push_back(model(16'h00E8, 3, 1, 16'h00E8));
    if_a.start = 1'b1;
    @(negedge clk);
    chk("b2b_idle", 32'(if_a.busy), 32'd0);
    @(negedge clk);
    if_a.start = 1'b0;
    chk("b2b_busy", 32'(if_a.busy),      32'd1);
    chk("b2b_err",  32'(if_a.err_count), 32'd0);
    chk("b2b_cap",  32'(if_a.capture),   32'd0);
    chk("b2b_pass", 32'(if_a.pass),      32'd0);
    wait_done_a();

    sweep_b(16'h8000);
    for (int k = 0; k < 3; k++) sweep_b(16'($urandom));
    sweep_b(16'h8000);

    repeat (5) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
